fifo_wr_arb: RTL and testbench



---
 rtl/fifo_wr_arb_if.sv | 23 ++
 rtl/fifo_wr_arb.sv | 98 +++++++++
 tb/tb_fifo_wr_arb.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arb_if.sv
// fifo_wr_arb_if: requester and FIFO-write bundle for fifo_wr_arb; abort exists only when FIFO_ARB_WATCHDOG_EN is defined
interface fifo_wr_arb_if #(
   parameter int NREQ = 4,
   parameter int DW = 8
);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] last;
   logic [NREQ*DW-1:0] din;
   logic [NREQ-1:0] ready;
   logic [NREQ-1:0] grant;
   logic busy;
   logic wr;
   logic [DW-1:0] wdata;
   logic wfull;
`ifdef FIFO_ARB_WATCHDOG_EN
   logic abort;
   modport slave (input req, last, din, wfull, output ready, grant, busy, wr, wdata, abort);
   modport master (output req, last, din, wfull, input ready, grant, busy, wr, wdata, abort);
`else
   modport slave (input req, last, din, wfull, output ready, grant, busy, wr, wdata);
   modport master (output req, last, din, wfull, input ready, grant, busy, wr, wdata);
`endif
endinterface

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter for the FIFO write port; FIFO_ARB_WATCHDOG_EN adds a stalled-owner watchdog
module fifo_wr_arb #(
   parameter int NREQ = 4,
   parameter int DW = 8,
   parameter int MAX_BURST = 8
`ifdef FIFO_ARB_WATCHDOG_EN
   , parameter int TIMEOUT = 16
`endif
) (
   input logic wclk,
   input logic wrst_n,
   fifo_wr_arb_if.slave bus
);
   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(MAX_BURST) + 1;
   typedef enum logic {IDLE, XFER} state_t;
   state_t state;
   logic [NREQ-1:0] grant_q;
   logic busy_q;
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] win;
   logic [PW-1:0] cand;
   logic [CW-1:0] beat_cnt;
   logic [DW-1:0] wdata_m;
   logic req_g;
   logic last_g;
   logic wr_c;
   logic end_burst;
   logic revoke;
   assign req_g = |(bus.req & grant_q);
   assign last_g = |(bus.last & grant_q);
   assign wr_c = req_g & ~bus.wfull;
   assign end_burst = wr_c & (last_g | (beat_cnt == CW'(MAX_BURST - 1)));
   assign bus.ready = grant_q & {NREQ{~bus.wfull}};
   assign bus.wr = wr_c;
   assign bus.wdata = wdata_m;
   assign bus.grant = grant_q;
   assign bus.busy = busy_q;
   // winner search from rr_ptr+1 upward with wrap; walking backwards leaves the nearest requester
   always_comb begin
      win = rr_ptr;
      cand = '0;
      for (int i = NREQ; i >= 1; i--) begin
         cand = PW'((int'(rr_ptr) + i) % NREQ);
         if (bus.req[cand]) win = cand;
      end
   end
   // AND-OR data mux; yields zero whenever nobody holds the grant
   always_comb begin
      wdata_m = '0;
      for (int i = 0; i < NREQ; i++) wdata_m = wdata_m | (bus.din[i*DW +: DW] & {DW{grant_q[i]}});
   end
`ifdef FIFO_ARB_WATCHDOG_EN
   localparam int SW = $clog2(TIMEOUT) + 1;
   logic [SW-1:0] stall_cnt;
   logic abort_q;
   logic idle_own;
   assign idle_own = (state == XFER) & ~req_g & ~bus.wfull;
   assign revoke = idle_own & (stall_cnt == SW'(TIMEOUT - 1));
   assign bus.abort = abort_q;
   // watchdog: count writable cycles the owner offers nothing; full-FIFO cycles hold the count
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         stall_cnt <= '0;
         abort_q <= 1'b0;
      end else begin
         abort_q <= revoke;
         stall_cnt <= (state != XFER || req_g || revoke) ? '0 : idle_own ? stall_cnt + 1'b1 : stall_cnt;
      end
   end
`else
   assign revoke = 1'b0;
`endif
   // arbitration FSM: grant on IDLE, count beats in XFER, drop back to IDLE on last, max beats or revoke
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state <= IDLE;
         grant_q <= '0;
         busy_q <= 1'b0;
         rr_ptr <= PW'(NREQ - 1);
         beat_cnt <= '0;
      end else if (state == IDLE) begin
         if (|bus.req) begin
            state <= XFER;
            grant_q <= NREQ'(1) << win;
            busy_q <= 1'b1;
            rr_ptr <= win;
            beat_cnt <= '0;
         end
      end else if (end_burst || revoke) begin
         state <= IDLE;
         grant_q <= '0;
         busy_q <= 1'b0;
      end else if (wr_c) begin
         beat_cnt <= beat_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed vector table plus hand-written burst, backpressure, stall and reset sequences
module tb_fifo_wr_arb;
   localparam int NREQ = 4;
   localparam int DW = 8;
   typedef struct {
      logic [3:0] req;
      logic [3:0] last;
      logic [31:0] din;
      logic wfull;
      logic [3:0] grant;
      logic [3:0] ready;
      logic wr;
      logic busy;
      logic [7:0] wdata;
   } vec_t;
   logic wclk = 1'b0;
   logic wrst_n = 1'b0;
   int checks = 0;
   int failures = 0;
   int n;
   int bad;
   vec_t tbl [8];
   fifo_wr_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();
   fifo_wr_arb #(.NREQ(NREQ), .DW(DW), .MAX_BURST(8)) dut (.wclk(wclk), .wrst_n(wrst_n), .bus(bus));
   always #5 wclk = ~wclk;
   function automatic vec_t mk(input logic [3:0] r, l, input logic [31:0] d, input logic f,
                               input logic [3:0] g, rd, input logic w, b, input logic [7:0] wd);
      vec_t v;
      v.req = r; v.last = l; v.din = d; v.wfull = f;
      v.grant = g; v.ready = rd; v.wr = w; v.busy = b; v.wdata = wd;
      return v;
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic cyc(input logic [3:0] r, l, input logic [31:0] d, input logic f);
      @(negedge wclk);
      bus.req = r; bus.last = l; bus.din = d; bus.wfull = f;
      #1;
   endtask
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
   initial begin
      tbl[0] = mk(4'b0001, 4'b0000, 32'h0000_0011, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00);
      tbl[1] = mk(4'b0001, 4'b0001, 32'h0000_0012, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 8'h12);
      tbl[2] = mk(4'b0100, 4'b0000, 32'h00A1_0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00);
      tbl[3] = mk(4'b0110, 4'b0010, 32'h00A1_5500, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, 8'hA1);
      tbl[4] = mk(4'b0100, 4'b0000, 32'h00A2_0000, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1, 8'hA2);
      tbl[5] = mk(4'b0100, 4'b0000, 32'h00A2_0000, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, 8'hA2);
      tbl[6] = mk(4'b0100, 4'b0100, 32'h00A3_0000, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, 8'hA3);
      tbl[7] = mk(4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 4; k++) begin
         cyc(4'($urandom), 4'($urandom), $urandom, 1'($urandom));
         chk("rst_grant", 32'(bus.grant), 0);
         chk("rst_wr", 32'(bus.wr), 0);
         chk("rst_ready", 32'(bus.ready), 0);
         chk("rst_busy", 32'(bus.busy), 0);
         chk("rst_wdata", 32'(bus.wdata), 0);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge wclk);
         wrst_n = 1'b1;
         bus.req = tbl[i].req; bus.last = tbl[i].last; bus.din = tbl[i].din; bus.wfull = tbl[i].wfull;
         #1;
         chk($sformatf("v%0d_grant", i), 32'(bus.grant), 32'(tbl[i].grant));
         chk($sformatf("v%0d_ready", i), 32'(bus.ready), 32'(tbl[i].ready));
         chk($sformatf("v%0d_wr", i), 32'(bus.wr), 32'(tbl[i].wr));
         chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
         chk($sformatf("v%0d_wdata", i), 32'(bus.wdata), 32'(tbl[i].wdata));
      end
      @(negedge wclk);
      wrst_n = 1'b0;
      @(negedge wclk);
      wrst_n = 1'b1;
      bus.req = 4'b1111; bus.last = 4'b0000; bus.din = 32'h3332_3130; bus.wfull = 1'b0;
      #1;
      chk("fair_gap", 32'(bus.grant), 0);
      for (int b = 0; b < 5; b++) begin
         n = 0;
         repeat (8) begin
            cyc(4'b1111, 4'b0000, 32'h3332_3130, 1'b0);
            if (bus.grant == 4'(1 << (b % 4)) && bus.wr && bus.wdata == 8'(8'h30 + b % 4)) n++;
         end
         chk($sformatf("fair_beats_b%0d", b), 32'(n), 8);
         cyc(4'b1111, 4'b0000, 32'h3332_3130, 1'b0);
         chk($sformatf("fair_gap_b%0d", b), 32'(bus.grant), 0);
      end
      n = 0;
      repeat (3) begin
         cyc(4'b0010, 4'b0000, 32'h3332_3130, 1'b0);
         if (bus.grant == 4'b0010 && bus.wr && bus.wdata == 8'h31) n++;
      end
      chk("bp_first_beats", 32'(n), 3);
      bad = 0;
      repeat (5) begin
         cyc(4'b0010, 4'b0000, 32'h3332_3130, 1'b1);
         if (bus.wr || bus.ready != 4'b0000 || bus.grant != 4'b0010) bad++;
      end
      chk("bp_stall_viol", 32'(bad), 0);
      n = 0;
      for (int k = 4; k <= 8; k++) begin
         cyc(4'b0010, (k == 8) ? 4'b0010 : 4'b0000, 32'h3332_3130, 1'b0);
         if (bus.wr && bus.ready == 4'b0010) n++;
      end
      chk("bp_resume_beats", 32'(n), 5);
      cyc(4'b0010, 4'b0000, 32'h3332_3130, 1'b0);
      chk("bp_end_grant", 32'(bus.grant), 0);
      chk("bp_end_busy", 32'(bus.busy), 0);
      cyc(4'b0010, 4'b0010, 32'h3332_3130, 1'b0);
      chk("bp_regrant", 32'(bus.grant), 32'(4'b0010));
      cyc(4'b1000, 4'b0000, 32'h3332_3130, 1'b0);
      chk("own_idle", 32'(bus.grant), 0);
      cyc(4'b1000, 4'b0000, 32'h3332_3130, 1'b0);
      chk("own_grant", 32'(bus.grant), 32'(4'b1000));
      chk("own_wdata", 32'(bus.wdata), 32'h33);
      bad = 0;
      repeat (4) begin
         cyc(4'b0000, 4'b0000, 32'h3332_3130, 1'b0);
         if (bus.grant != 4'b1000 || bus.wr) bad++;
      end
      chk("own_stall_viol", 32'(bad), 0);
      @(negedge wclk);
      bus.req = 4'b1001;
      #2;
      wrst_n = 1'b0;
      #1;
      chk("arst_grant", 32'(bus.grant), 0);
      chk("arst_busy", 32'(bus.busy), 0);
      chk("arst_wr", 32'(bus.wr), 0);
      chk("arst_ready", 32'(bus.ready), 0);
      @(negedge wclk);
      wrst_n = 1'b1;
      #1;
      chk("arst_idle", 32'(bus.grant), 0);
      cyc(4'b1001, 4'b0000, 32'h3332_3130, 1'b0);
      chk("arst_rr_restart", 32'(bus.grant), 32'(4'b0001));
`ifdef FIFO_ARB_WATCHDOG_EN
      n = 0;
      for (int k = 1; k <= 40; k++) begin
         cyc(4'b0000, 4'b0000, 32'h3332_3130, 1'b0);
         n = k;
         if (bus.abort) break;
      end
      chk("wd_abort_cycle", 32'(n), 17);
      chk("wd_grant", 32'(bus.grant), 0);
      cyc(4'b0000, 4'b0000, 32'h3332_3130, 1'b0);
      chk("wd_abort_pulse", 32'(bus.abort), 0);
`else
      repeat (100) cyc(4'b0000, 4'b0000, 32'h3332_3130, 1'b0);
      chk("hold_grant", 32'(bus.grant), 32'(4'b0001));
      chk("hold_busy", 32'(bus.busy), 1);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
